// File: rtl/sample_rx.sv
// UART-style sample receiver feeding the FIR tap shift register: 8N1 frames, LSB first.
// Emits each good byte with a one-cycle valid strobe and flags bad stop bits.
module sample_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  logic cnt_clr, cnt_inc, idx_clr, shift_en, valid_set, err_set;
  logic at_mid, at_last;

  assign at_mid  = (cnt == MID_CNT);
  assign at_last = (cnt == LAST_CNT);

  // NOTE: the synchroniser resets to 1 (idle line) so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en && !rx_s)              state_nxt = START;
      START: if (at_mid)                   state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (at_last && idx == 3'd7)   state_nxt = STOP;
      STOP:  if (at_last)                  state_nxt = rx_s ? IDLE : BRK;
      BRK:   if (rx_s)                     state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from the current state; stop-bit decision is made mid-bit.
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    idx_clr   = 1'b0;
    shift_en  = 1'b0;
    valid_set = 1'b0;
    err_set   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
      end
      START: begin
        idx_clr = 1'b1;
        if (at_mid) cnt_clr = 1'b1;
        else        cnt_inc = 1'b1;
      end
      DATA: begin
        if (at_last) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
        end else begin
          cnt_inc  = 1'b1;
        end
      end
      STOP: begin
        if (at_last) begin
          cnt_clr   = 1'b1;
          valid_set = rx_s;
          err_set   = !rx_s;
        end else begin
          cnt_inc   = 1'b1;
        end
      end
      BRK:     cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= valid_set;
      frame_err    <= err_set;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (idx_clr)       idx <= '0;
      else if (shift_en) idx <= idx + 3'd1;
      if (shift_en)  shreg  <= {rx_s, shreg[7:1]};
      if (valid_set) sample <= shreg;
    end
  end

endmodule

// File: tb/tb_sample_rx.sv
// Self-checking bench for sample_rx: directed scenarios plus random frames, scored against
// an event queue of expected pulses computed from the frame-timing rule.
module tb_sample_rx;

  localparam int CPB     = 16;
  localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       rx;
  logic [7:0] sample;
  logic       sample_valid;
  logic       frame_err;
  logic       busy;

  sample_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rx           (rx),
    .sample       (sample),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_sample = 8'h00;
  int         checks   = 0;
  int         failures = 0;
  int         busy_e0  = -1;
  bit         en_watch = 1'b0;
  bit         busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard: every pulse must be due, every due event must pulse.
  ev_t e;
  bit  due;
  always @(negedge clk) begin
    if (!reset) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (sample_valid || frame_err || due) begin
        if (due) begin
          e = exp_q.pop_front();
          check("valid_pulse", sample_valid, !e.is_err);
          check("ferr_pulse", frame_err, e.is_err);
          if (!e.is_err) model_sample = e.data;
          check("sample_at_pulse", sample, model_sample);
        end else begin
          check("spurious_valid", sample_valid, 0);
          check("spurious_ferr", frame_err, 0);
        end
      end
      if (busy_e0 >= 0) begin
        if (cyc == busy_e0 + 1)   check("busy_before", busy, 0);
        if (cyc == busy_e0 + 2)   check("busy_rise", busy, 1);
        if (cyc == busy_e0 + 153) check("busy_hold", busy, 1);
        if (cyc == busy_e0 + 154) check("busy_fall", busy, 0);
      end
      if (en_watch) busy_seen |= busy;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit exp_it, input bit drop_en);
    int e0;
    e0 = cyc + 1;
    if (exp_it) exp_q.push_back('{is_err: !stop, data: d, cyc: e0 + LATENCY});
    drive_bit(1'b0);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (drop_en) en = 1'b1;
    drive_bit(stop);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sample"}, sample, 8'h00);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    idle(5);

    // Single frame with latency and busy window.
    busy_e0 = cyc + 1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(20);
    busy_e0 = -1;
    check("a5_held", sample, 8'hA5);

    // Back-to-back frames, no idle gap.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 1'b0);
    idle(20);
    check("b2b_last", sample, 8'hFE);

    // Short glitch on the line is rejected at mid start bit.
    begin
      int g0;
      g0 = cyc + 1;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (g0 + 5 - cyc) @(negedge clk);
      check("glitch_busy", busy, 1);
      repeat (15) @(negedge clk);
      check("glitch_idle", busy, 0);
      check("glitch_sample", sample, 8'hFE);
    end

    // Bad stop bit, line held low, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("break_busy", busy, 1);
    idle(10);
    check("after_break_sample", sample, 8'hFE);
    send_frame(8'h77, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Reset during data bit 4 discards the frame.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_quiet("midreset");
    model_sample = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    idle(20);
    check("midreset_after", sample, 8'h00);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Receiver disabled: a whole frame goes unseen.
    en        = 1'b0;
    busy_seen = 1'b0;
    en_watch  = 1'b1;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(20);
    en_watch = 1'b0;
    check("disabled_busy", busy_seen, 0);
    check("disabled_sample", sample, 8'h5A);
    en = 1'b1;
    idle(10);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Line low at reset release: all-zero frame ending in a framing error, then BREAK.
    rx    = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    model_sample = 8'h00;
    reset = 1'b0;
    exp_q.push_back('{is_err: 1'b1, data: 8'h00, cyc: cyc + 1 + LATENCY});
    repeat (200) @(negedge clk);
    check("lowrst_break", busy, 1);
    idle(10);
    check("lowrst_idle", busy, 0);
    check("lowrst_sample", sample, 8'h00);

    // Random frames: random data, gaps (including none), bad stops and mid-frame en drops.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit         bad;
      bit         drop;
      d    = 8'($urandom);
      bad  = ($urandom_range(0, 5) == 0);
      drop = ($urandom_range(0, 3) == 0);
      send_frame(d, !bad, 1'b1, drop);
      if (bad) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        idle($urandom_range(2, 10));
      end else begin
        idle($urandom_range(0, 20));
      end
    end

    idle(200);
    check("queue_drained", exp_q.size(), 0);
    check("final_sample", sample, model_sample);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
